// File: rtl/reg_bank_mp_if.sv
// Bus bundle for the multi-read-port register bank: one write port, one reserve
// port and NRD read ports, with read addresses and data packed port by port.
interface reg_bank_mp_if #(
  parameter int WL  = 32,
  parameter int AL  = 5,
  parameter int NRD = 2
);
  logic              wr_en;
  logic [AL-1:0]     w_addr;
  logic [WL-1:0]     w_data;
  logic              rsv_en;
  logic [AL-1:0]     rsv_addr;
  logic [NRD-1:0]    rd_en;
  logic [NRD*AL-1:0] r_addr;
  logic [NRD*WL-1:0] r_data;
  logic [NRD-1:0]    r_valid;
  logic [NRD-1:0]    r_pending;

  modport master (
    output wr_en, w_addr, w_data, rsv_en, rsv_addr, rd_en, r_addr,
    input  r_data, r_valid, r_pending
  );

  modport slave (
    input  wr_en, w_addr, w_data, rsv_en, rsv_addr, rd_en, r_addr,
    output r_data, r_valid, r_pending
  );
endinterface

// File: rtl/reg_bank_mp.sv
// Register bank with NRD registered read ports, write-first bypass, optional
// hard-wired zero entry and a per-entry pending scoreboard.
module reg_bank_mp #(
  parameter int WL       = 32,
  parameter int AL       = 5,
  parameter int NRD      = 2,
  parameter int ZERO_REG = 1
) (
  input  logic         clk,
  input  logic         rst_n,
  reg_bank_mp_if.slave bus
);
  localparam int DEPTH = 1 << AL;

  logic [WL-1:0]    mem_reg [DEPTH];
  logic [DEPTH-1:0] pend_reg;
  logic             wr_ok;
  logic             rsv_ok;

  // Entry 0 swallows writes and reservations when it is the zero register.
  assign wr_ok  = bus.wr_en  && !((ZERO_REG != 0) && (bus.w_addr == '0));
  assign rsv_ok = bus.rsv_en && !((ZERO_REG != 0) && (bus.rsv_addr == '0));

  // Reservation is applied after the write clear so it wins on the same entry.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int e = 0; e < DEPTH; e++) begin
        mem_reg[e] <= '0;
      end
      pend_reg <= '0;
    end else begin
      if (wr_ok) begin
        mem_reg[bus.w_addr]  <= bus.w_data;
        pend_reg[bus.w_addr] <= 1'b0;
      end
      if (rsv_ok) begin
        pend_reg[bus.rsv_addr] <= 1'b1;
      end
    end
  end

  for (genvar gi = 0; gi < NRD; gi++) begin : g_port
    logic [AL-1:0] addr;
    logic          zero_hit;
    logic [WL-1:0] data_next;
    logic          pend_next;
    logic [WL-1:0] data_reg;
    logic          pend_out_reg;
    logic          valid_reg;

    assign addr     = bus.r_addr[gi*AL +: AL];
    assign zero_hit = (ZERO_REG != 0) && (addr == '0);

    // Port sees the entry as it will stand after this edge's write and reserve.
    always_comb begin
      data_next = mem_reg[addr];
      pend_next = pend_reg[addr];
      if (wr_ok && (bus.w_addr == addr)) begin
        data_next = bus.w_data;
        pend_next = 1'b0;
      end
      if (rsv_ok && (bus.rsv_addr == addr)) begin
        pend_next = 1'b1;
      end
      if (zero_hit) begin
        data_next = '0;
        pend_next = 1'b0;
      end
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        data_reg     <= '0;
        pend_out_reg <= 1'b0;
        valid_reg    <= 1'b0;
      end else begin
        valid_reg <= bus.rd_en[gi];
        if (bus.rd_en[gi]) begin
          data_reg     <= data_next;
          pend_out_reg <= pend_next;
        end
      end
    end

    assign bus.r_data[gi*WL +: WL] = data_reg;
    assign bus.r_pending[gi]       = pend_out_reg;
    assign bus.r_valid[gi]         = valid_reg;
  end
endmodule

// File: tb/tb_reg_bank_mp.sv
// Directed bench: a 2-port bank with zero register, and a 4-port 8-entry bank
// without one, the latter also checked against a small reference model.
module tb_reg_bank_mp;
  logic clk = 1'b0;
  logic rst_n = 1'b1;
  int n_checks = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  reg_bank_mp_if #(.WL(32), .AL(5), .NRD(2)) bus_a ();
  reg_bank_mp_if #(.WL(32), .AL(3), .NRD(4)) bus_b ();

  reg_bank_mp #(.WL(32), .AL(5), .NRD(2), .ZERO_REG(1)) dut_a (
    .clk(clk), .rst_n(rst_n), .bus(bus_a)
  );
  reg_bank_mp #(.WL(32), .AL(3), .NRD(4), .ZERO_REG(0)) dut_b (
    .clk(clk), .rst_n(rst_n), .bus(bus_b)
  );

  logic [31:0] m_mem [8];
  logic        m_pend [8];

  task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic a_idle();
    bus_a.wr_en = 1'b0; bus_a.w_addr = '0; bus_a.w_data = '0;
    bus_a.rsv_en = 1'b0; bus_a.rsv_addr = '0;
    bus_a.rd_en = '0; bus_a.r_addr = '0;
  endtask

  task automatic a_read(input logic [1:0] en, input logic [4:0] a0, input logic [4:0] a1);
    bus_a.rd_en = en;
    bus_a.r_addr = {a1, a0};
  endtask

  task automatic a_write(input logic [4:0] a, input logic [31:0] d);
    bus_a.wr_en = 1'b1; bus_a.w_addr = a; bus_a.w_data = d;
  endtask

  // Drive one cycle on bank B, advance the model, then check all four ports.
  task automatic b_step(input logic we, input logic [2:0] wa, input logic [31:0] wd,
                        input logic re, input logic [2:0] ra, input logic [2:0] base);
    logic [2:0] pa [4];
    pa[0] = base; pa[1] = base + 3'd1; pa[2] = base + 3'd2; pa[3] = base + 3'd2;
    bus_b.wr_en = we; bus_b.w_addr = wa; bus_b.w_data = wd;
    bus_b.rsv_en = re; bus_b.rsv_addr = ra;
    bus_b.rd_en = 4'hF;
    bus_b.r_addr = {pa[3], pa[2], pa[1], pa[0]};
    if (we) begin m_mem[wa] = wd; m_pend[wa] = 1'b0; end
    if (re) m_pend[ra] = 1'b1;
    tick();
    for (int i = 0; i < 4; i++) begin
      check_eq($sformatf("b_data%0d", i), bus_b.r_data[i*32 +: 32], m_mem[pa[i]]);
      check_eq($sformatf("b_pend%0d", i), bus_b.r_pending[i], m_pend[pa[i]]);
    end
    check_eq("b_valid", bus_b.r_valid, 4'hF);
    check_eq("b_same_addr_pair", bus_b.r_data[95:64], bus_b.r_data[127:96]);
  endtask

  initial begin
    a_idle();
    bus_b.wr_en = 1'b0; bus_b.w_addr = '0; bus_b.w_data = '0;
    bus_b.rsv_en = 1'b0; bus_b.rsv_addr = '0;
    bus_b.rd_en = '0; bus_b.r_addr = '0;
    for (int e = 0; e < 8; e++) begin m_mem[e] = '0; m_pend[e] = 1'b0; end

    #2 rst_n = 1'b0;
    #1;
    check_eq("rst_data", bus_a.r_data, 64'h0);
    check_eq("rst_valid", bus_a.r_valid, 2'b00);
    check_eq("rst_pending", bus_a.r_pending, 2'b00);
    repeat (2) @(posedge clk);
    #3 rst_n = 1'b1;

    // Every entry reads 0 after reset.
    for (int a = 0; a < 32; a++) begin
      a_read(2'b11, 5'(a), 5'(31 - a));
      tick();
      check_eq($sformatf("init_data_%0d", a), bus_a.r_data, 64'h0);
      check_eq($sformatf("init_valid_%0d", a), bus_a.r_valid, 2'b11);
      check_eq($sformatf("init_pend_%0d", a), bus_a.r_pending, 2'b00);
      $display("read addr %0d/%0d -> %0h", a, 31 - a, bus_a.r_data);
    end

    // Plain write then read, and same-edge bypass on port 1.
    a_idle(); a_write(5'd7, 32'hDEADBEEF); tick();
    a_idle(); a_read(2'b01, 5'd7, 5'd0); tick();
    check_eq("wr_rd_7", bus_a.r_data[31:0], 32'hDEADBEEF);
    check_eq("wr_rd_7_valid", bus_a.r_valid, 2'b01);
    a_write(5'd9, 32'h12345678); a_read(2'b10, 5'd7, 5'd9); tick();
    check_eq("bypass_9", bus_a.r_data[63:32], 32'h12345678);
    check_eq("bypass_valid", bus_a.r_valid, 2'b10);
    check_eq("hold_p0", bus_a.r_data[31:0], 32'hDEADBEEF);
    $display("bypass write 9 -> %0h", bus_a.r_data[63:32]);

    // Zero register ignores write and reserve.
    a_idle(); a_write(5'd0, 32'hFFFFFFFF); bus_a.rsv_en = 1'b1; bus_a.rsv_addr = 5'd0;
    a_read(2'b01, 5'd0, 5'd0); tick();
    check_eq("zero_bypass_data", bus_a.r_data[31:0], 32'h0);
    a_idle(); a_read(2'b11, 5'd0, 5'd0); tick();
    check_eq("zero_data", bus_a.r_data, 64'h0);
    check_eq("zero_pend", bus_a.r_pending, 2'b00);

    // Scoreboard on entry 3.
    a_idle(); bus_a.rsv_en = 1'b1; bus_a.rsv_addr = 5'd3; tick();
    a_idle(); a_read(2'b01, 5'd3, 5'd0); tick();
    check_eq("rsv3_pend", bus_a.r_pending[0], 1'b1);
    check_eq("rsv3_data", bus_a.r_data[31:0], 32'h0);
    a_write(5'd3, 32'h55); tick();
    check_eq("wb3_pend", bus_a.r_pending[0], 1'b0);
    check_eq("wb3_data", bus_a.r_data[31:0], 32'h55);
    a_idle(); a_write(5'd3, 32'h55); bus_a.rsv_en = 1'b1; bus_a.rsv_addr = 5'd3;
    a_read(2'b10, 5'd0, 5'd3); tick();
    check_eq("rsvwr3_pend", bus_a.r_pending[1], 1'b1);
    check_eq("rsvwr3_data", bus_a.r_data[63:32], 32'h55);
    a_idle(); a_read(2'b11, 5'd3, 5'd3); tick();
    check_eq("rsvwr3_pend_after", bus_a.r_pending, 2'b11);
    check_eq("rsvwr3_data_after", bus_a.r_data, {32'h55, 32'h55});

    // Read enable low holds data while entry 4 changes underneath.
    a_idle(); a_write(5'd4, 32'hA5); tick();
    a_idle(); a_read(2'b01, 5'd4, 5'd0); tick();
    check_eq("rd4_data", bus_a.r_data[31:0], 32'hA5);
    for (int c = 0; c < 3; c++) begin
      a_idle(); a_write(5'd4, 32'h5A); tick();
      check_eq($sformatf("hold4_valid_%0d", c), bus_a.r_valid, 2'b00);
      check_eq($sformatf("hold4_data_%0d", c), bus_a.r_data[31:0], 32'hA5);
    end
    a_idle(); a_read(2'b01, 5'd4, 5'd0); tick();
    check_eq("reen4_data", bus_a.r_data[31:0], 32'h5A);
    check_eq("reen4_valid", bus_a.r_valid, 2'b01);
    $display("re-enabled read addr 4 -> %0h", bus_a.r_data[31:0]);

    // Asynchronous reset in the middle of a write and a read.
    a_idle(); a_write(5'd10, 32'h77); a_read(2'b11, 5'd7, 5'd3); tick();
    check_eq("pre_rst_valid", bus_a.r_valid, 2'b11);
    check_eq("pre_rst_data", bus_a.r_data[31:0], 32'hDEADBEEF);
    #2 rst_n = 1'b0;
    #1;
    check_eq("async_rst_data", bus_a.r_data, 64'h0);
    check_eq("async_rst_valid", bus_a.r_valid, 2'b00);
    check_eq("async_rst_pend", bus_a.r_pending, 2'b00);
    a_idle();
    @(posedge clk);
    #3 rst_n = 1'b1;
    a_read(2'b11, 5'd7, 5'd3); tick();
    check_eq("post_rst_data", bus_a.r_data, 64'h0);
    check_eq("post_rst_pend", bus_a.r_pending, 2'b00);
    a_read(2'b01, 5'd10, 5'd0); tick();
    check_eq("post_rst_10", bus_a.r_data[31:0], 32'h0);

    // Bank B: entry 0 is ordinary; write and reserve both stick.
    b_step(1'b1, 3'd0, 32'hFFFFFFFF, 1'b1, 3'd0, 3'd0);
    check_eq("b_zero_data", bus_b.r_data[31:0], 32'hFFFFFFFF);
    check_eq("b_zero_pend", bus_b.r_pending[0], 1'b1);
    $display("bank B read addr 0 -> %0h pend %0b", bus_b.r_data[31:0], bus_b.r_pending[0]);

    for (int n = 0; n < 40; n++) begin
      b_step(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), $urandom,
             1'($urandom_range(0, 3) == 0), 3'($urandom_range(0, 7)),
             3'($urandom_range(0, 7)));
      $display("bank B cycle %0d: w%0b@%0d rsv%0b@%0d data %0h", n, bus_b.wr_en,
               bus_b.w_addr, bus_b.rsv_en, bus_b.rsv_addr, bus_b.r_data);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/reg_bank_mp.md
Name: reg_bank_mp

Overview:
Parametrised multi-read-port register bank, the successor to the single-write/dual-read register bank. Adds the following over that bank:
- N registered read ports with 1-cycle latency.
- Write-to-read bypass.
- Optional hard-wired zero register.
- Asynchronous reset clear.
- Per-entry pending scoreboard, so consumers can detect operands whose producer has not yet written back.

Sits between the decode/issue stage and the execute/writeback stages of the datapath.

Parameters:
WL, 32, data word length in bits
AL, 5, address bits; depth = 2**AL entries
NRD, 2, number of read ports (>=1)
ZERO_REG, 1, 1: entry 0 reads as 0, ignores writes and reservations; 0: entry 0 is an ordinary register

Ports:
clk  input  1  clock; all state updates on rising edge
rst_n  input  1  asynchronous active-low reset
wr_en  input  1  write strobe
w_addr  input  AL  write address
w_data  input  WL  write data
rsv_en  input  1  reserve strobe: marks entry rsv_addr pending
rsv_addr  input  AL  entry to reserve
rd_en  input  NRD  per-port read enable
r_addr  input  NRD*AL  read addresses; port i at [i*AL +: AL]
r_data  output  NRD*WL  read data; port i at [i*WL +: WL]
r_valid  output  NRD  port i data updated in the previous cycle
r_pending  output  NRD  entry read on port i was pending at sample time

Behaviour:
Reset:
- One clock; reset is asynchronous and active-low (clk, rst_n).
- Asserting rst_n=0 at any time immediately clears every entry to 0, all pending bits to 0, r_data to 0, r_valid to 0 and r_pending to 0. This includes mid-write and mid-read.
- No state change while rst_n=0. The first active edge follows rst_n deassertion.

Write:
- On posedge, if wr_en=1 then RB[w_addr] <= w_data and pend[w_addr] <= 0.
- Exception: when ZERO_REG=1 and w_addr=0, the write is dropped.

Reserve:
- On posedge, if rsv_en=1 then pend[rsv_addr] <= 1.
- Ignored when ZERO_REG=1 and rsv_addr=0.
- Same edge, same address as a write: the reservation wins, pend=1, and the data is still written. A new producer has claimed the entry.
- Reserve and write to different addresses apply independently.

Read, per port i, independent of the other ports:
- On posedge with rd_en[i]=1:
  - r_data[i] <= value at r_addr[i] after the same-edge write is applied (write-first bypass): if wr_en and w_addr==r_addr[i] and the write is not dropped, the port returns w_data.
  - r_pending[i] <= pend[r_addr[i]] after the same-edge write clear and reservation set.
  - r_valid[i] <= 1.
- With rd_en[i]=0: r_valid[i] <= 0; r_data[i] and r_pending[i] hold their previous values. Outputs are never X.
- ZERO_REG=1 and r_addr[i]=0: r_data[i] <= 0 and r_pending[i] <= 0.
- Latency is exactly 1 cycle from the address-sample edge to data on the outputs.
- Multiple ports may read the same address on the same edge; all return identical data.

Width and range:
- Addresses are full range 0..2**AL-1; no out-of-range case exists.
- Read/write data width is WL; no truncation or extension.

Scoreboard contract:
- Data is guaranteed current only when r_pending[i]=0.
- The block does not stall; the consumer decides on stalls.

Test Plan:
1. Reset, then read all addresses on both ports -> r_data=0, r_valid=1 the cycle after each read, r_pending=0. Assert rst_n=0 mid-stream -> outputs go to 0 without waiting for clk.
2. Write 0xDEADBEEF to addr 7; next cycle read port0 addr 7 -> r_data0=0xDEADBEEF one cycle later. Same-edge write 0x12345678 to addr 9 with read port1 addr 9 -> r_data1=0x12345678 (bypass).
3. ZERO_REG=1: write 0xFFFFFFFF to addr 0 and reserve addr 0, then read addr 0 -> r_data=0, r_pending=0. Rerun with ZERO_REG=0 -> r_data=0xFFFFFFFF.
4. Reserve addr 3, read addr 3 -> r_pending=1. Write addr 3 = 0x55, same-edge read -> r_pending=0, r_data=0x55. Reserve+write addr 3 on the same edge -> pend stays 1, data 0x55 written.
5. Read addr 4 with 0xA5, then hold rd_en=0 for 3 cycles while writing addr 4 = 0x5A -> r_valid=0, r_data holds 0xA5. Re-enable -> r_data=0x5A.
6. NRD=4, AL=3, all ports reading distinct addresses plus one same-address pair under random writes -> every port matches the reference model each cycle; the same-address pair returns identical data.
